// File: rtl/regfile_mp.sv
// regfile_mp -- multi-ported register file with a per-register busy scoreboard.
//   * NRD combinational read ports, two write ports (wr1 wins on a shared address).
//   * Register 0 is hard-wired to zero and is never busy.
//   * busy_vec tracks one outstanding writer per register: an issue sets the bit,
//     and a write-back on either port clears it. If an issue and a write-back hit
//     the same register in one cycle, the issue wins.
//   * Optional build macro REGFILE_BYPASS_EN: same-cycle write data is forwarded
//     to matching read ports, and the forwarded register reads as not busy unless
//     it is being issued in that same cycle.
//   * reset is asynchronous and active-high. While it is high, every output reads
//     zero.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_wr0_hit;
  logic             w_wr1_hit;
  logic             w_iss_hit;

  // Accesses that target register 0 are dropped here, so nothing downstream can touch it.
  assign w_wr0_hit = wr0_en && (wr0_addr != {AW{1'b0}});
  assign w_wr1_hit = wr1_en && (wr1_addr != {AW{1'b0}});
  assign w_iss_hit = iss_en && (iss_addr != {AW{1'b0}});

  // Register storage: wr1 is applied after wr0, so wr1 wins when both target the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (w_wr0_hit) begin
        r_regs[wr0_addr] <= wr0_data;
      end
      if (w_wr1_hit) begin
        r_regs[wr1_addr] <= wr1_data;
      end
    end
  end

  // Next scoreboard state: an issue sets the bit, a write-back clears it, and the issue wins a tie.
  for (genvar i = 0; i < NREGS; i++) begin : g_busy
    if (i == 0) begin : g_zero
      assign w_busy_nxt[i] = 1'b0;
    end else begin : g_reg
      assign w_busy_nxt[i] =
        (w_iss_hit && (iss_addr == AW'(i))) ||
        (r_busy[i] && !(w_wr0_hit && (wr0_addr == AW'(i)))
                   && !(w_wr1_hit && (wr1_addr == AW'(i))));
    end
  end

  // Scoreboard register; any same-cycle issue or write is discarded when reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= {NREGS{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  // Read ports: each port is fully independent and purely combinational.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;
    logic            w_zero;

    assign w_addr = rd_addr[k*AW +: AW];
    assign w_zero = (w_addr == {AW{1'b0}});

`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle write data (wr1 over wr0); a forwarded register is busy only if it is being issued now.
    always_comb begin
      w_data = r_regs[w_addr];
      w_busy = r_busy[w_addr];
      if (w_wr1_hit && (wr1_addr == w_addr)) begin
        w_data = wr1_data;
        w_busy = w_iss_hit && (iss_addr == w_addr);
      end else if (w_wr0_hit && (wr0_addr == w_addr)) begin
        w_data = wr0_data;
        w_busy = w_iss_hit && (iss_addr == w_addr);
      end else begin
        w_data = r_regs[w_addr];
        w_busy = r_busy[w_addr];
      end
    end
`else
    assign w_data = r_regs[w_addr];
    assign w_busy = r_busy[w_addr];
`endif

    // Register 0 and the reset state both read as zero and never busy.
    assign rd_data[k*XLEN +: XLEN] = (reset || w_zero) ? {XLEN{1'b0}} : w_data;
    assign rd_busy[k]              = ~reset & ~w_zero & w_busy;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of every register.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of two, 2..64); AW = clog2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_addr  input  NRD*AW  read addresses, port k in bits [k*AW +: AW].
REQ-007 SHALL have port rd_data  output  NRD*XLEN  read data, port k in bits [k*XLEN +: XLEN].
REQ-008 SHALL have port rd_busy  output  NRD  per read port: addressed register has a pending write.
REQ-009 SHALL have ports wr0_en, wr1_en  input  1 each  write-port enables.
REQ-010 SHALL have ports wr0_addr, wr1_addr  input  AW each  write addresses.
REQ-011 SHALL have ports wr0_data, wr1_data  input  XLEN each  write data.
REQ-012 SHALL have port iss_en  input  1  issue strobe: mark iss_addr busy.
REQ-013 SHALL have port iss_addr  input  AW  destination register of the issuing instruction.
REQ-014 SHALL have port busy_vec  output  NREGS  registered scoreboard state, bit i = register i busy.

Function
REQ-015 Register 0 SHALL always read 0, never be written, never be busy; writes and issues to address 0 are ignored.
REQ-016 Reads SHALL be combinational; rd_data for port k reflects stored register rd_addr[k] in the same cycle.
REQ-017 Write with wrN_en=1 and nonzero address SHALL update the register on the next rising clk edge (1-cycle write latency).
REQ-018 Both write ports targeting the same nonzero address in one cycle: wr1 data SHALL win.
REQ-019 Write on either port SHALL clear the busy bit of its address at the same edge.
REQ-020 iss_en=1 with nonzero iss_addr SHALL set that busy bit at the next edge.
REQ-021 Issue and write-back to the same address in one cycle: busy SHALL end set (issue wins); register data still updated.
REQ-022 Issue to an already-busy register SHALL leave it busy (no counting; one outstanding writer per register).
REQ-023 rd_busy[k] SHALL equal busy_vec[rd_addr[k]] (subject to REQ-027 bypass), 0 for address 0.
REQ-024 Multiple read ports SHALL be fully independent; identical addresses return identical data.

Reset
REQ-025 While reset is high, all registers SHALL be 0, busy_vec SHALL be 0, rd_busy 0, rd_data 0 for every port; write and issue inputs ignored.
REQ-026 Reset asserted mid-operation SHALL take effect immediately, without a clock edge, discarding any same-cycle write or issue.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined: a read whose nonzero address matches an enabled write address in the same cycle SHALL return that write data (wr1 over wr0), and rd_busy SHALL read 0 for that address unless iss_en targets it the same cycle.
REQ-028 Without REGFILE_BYPASS_EN: reads SHALL return stored values only; new data is visible the cycle after the write edge, rd_busy reflects busy_vec only.
REQ-029 busy_vec SHALL be unaffected by REGFILE_BYPASS_EN (always registered state).

Verification
REQ-030 Reset, then read all addresses on every port -> rd_data 0, busy_vec 0; write x0=0xDEADBEEF -> x0 still reads 0.
REQ-031 wr0 x5=0x11111111 and wr1 x5=0x22222222 same cycle -> next cycle x5 reads 0x22222222.
REQ-032 Issue x7, wait 3 cycles -> busy_vec[7]=1, rd_busy=1 when reading x7; wr0 x7=0xA5A5A5A5 -> busy cleared next cycle, data 0xA5A5A5A5.
REQ-033 Same cycle iss_en x9 and wr1 x9=0x1234 -> after edge busy_vec[9]=1, x9 reads 0x1234.
REQ-034 Read x3 while wr0 x3=0xCAFEF00D: with REGFILE_BYPASS_EN -> same-cycle rd_data 0xCAFEF00D, rd_busy 0; without -> old value, new value next cycle.
REQ-035 Write x4=0x55 and issue x6, assert reset asynchronously between edges -> all outputs 0 immediately; after release x4 reads 0, busy_vec 0.
